// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, fetches from variable-latency instruction memory and
// hands instructions downstream over valid/ready. Optional macro: DELAY_SLOT_EN.
`default_nettype none

module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              branchC,
    input  logic              zero,
    input  logic [31:0]       branch_imm,
    input  logic              jumpC,
    input  logic [25:0]       jump_label
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ins_q, ins_d;
    logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic              buf_v_q, buf_v_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
`ifdef DELAY_SLOT_EN
    logic              pend_q, pend_d;
`endif

    logic              consume, done, in_flight, redir, accept;
    logic [ADDR_W-1:0] pc4, target;
    logic [31:0]       imm_sh;

    assign consume   = valid_q & ins_ready;
    assign done      = req_q & imem_ack;
    assign in_flight = req_q & ~imem_ack;
    assign pc4       = ins_pc_q + ADDR_W'(4);
    assign imm_sh    = branch_imm << 2;
    assign redir     = consume & (state_q == FETCH) & (jumpC | (branchC & zero));
    assign target    = jumpC ? {pc4[ADDR_W-1 -: 4], jump_label, 2'b00} : (pc4 + imm_sh);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ins_d    = ins_q;
        ins_pc_d = ins_pc_q;
        valid_d  = valid_q;
        buf_d    = buf_q;
        buf_pc_d = buf_pc_q;
        buf_v_d  = buf_v_q;
        tgt_d    = tgt_q;
`ifdef DELAY_SLOT_EN
        pend_d   = pend_q;
`endif
        accept   = done & (state_q == FETCH);

        // Output slot is backed by a one-word skid so a request issued on consume never loses data.
        if (consume) begin
            if (buf_v_q) begin
                ins_d    = buf_q;
                ins_pc_d = buf_pc_q;
                buf_v_d  = 1'b0;
            end else begin
                valid_d  = 1'b0;
            end
        end

        if (redir) begin
`ifdef DELAY_SLOT_EN
            // A buffered word is the delay slot, so whatever is in flight is wrong-path.
            if (buf_v_q) accept = 1'b0;
`else
            valid_d = 1'b0;
            buf_v_d = 1'b0;
            accept  = 1'b0;
`endif
        end

        if (accept) begin
            if (valid_d) begin
                buf_d    = imem_rdata;
                buf_pc_d = addr_q;
                buf_v_d  = 1'b1;
            end else begin
                ins_d    = imem_rdata;
                ins_pc_d = addr_q;
                valid_d  = 1'b1;
            end
        end

        if (state_q == DROP) begin
            if (imem_ack) begin
                pc_d    = tgt_q;
                state_d = FETCH;
            end
        end else begin
            if (done) pc_d = pc_q + ADDR_W'(4);
`ifdef DELAY_SLOT_EN
            if (done && pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end
            if (redir) begin
                if (buf_v_q || done) begin
                    if (in_flight) begin
                        state_d = DROP;
                        tgt_d   = target;
                    end else begin
                        pc_d    = target;
                    end
                end else begin
                    // Delay slot not fetched yet: redirect once it completes.
                    pend_d = 1'b1;
                    tgt_d  = target;
                end
            end
`else
            if (redir) begin
                if (in_flight) begin
                    state_d = DROP;
                    tgt_d   = target;
                end else begin
                    pc_d    = target;
                end
            end
`endif
        end

        if (!in_flight) begin
            addr_d = pc_d;
            req_d  = (state_d == FETCH) && (!valid_q || consume) && !buf_v_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            ins_q    <= '0;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
            buf_q    <= '0;
            buf_pc_q <= '0;
            buf_v_q  <= 1'b0;
            tgt_q    <= '0;
`ifdef DELAY_SLOT_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ins_q    <= ins_d;
            ins_pc_q <= ins_pc_d;
            valid_q  <= valid_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            buf_v_q  <= buf_v_d;
            tgt_q    <= tgt_d;
`ifdef DELAY_SLOT_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = valid_q;

endmodule

`default_nettype wire
